// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared state encoding for the bit-serial adder
package serial_adder_pkg;
    // Encoding 2'd3 is unused; the FSM treats it as IDLE.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;
endpackage

// File: rtl/serial_adder_if.sv
// serial_adder_if: start/done handshake and operand/result bus of serial_adder
// master drives start, a, b, cin; slave drives busy, done, sum, cout
interface serial_adder_if #(parameter int WIDTH = 8);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    modport master (output start, a, b, cin, input busy, done, sum, cout);
    modport slave  (input start, a, b, cin, output busy, done, sum, cout);
endinterface

// File: rtl/serial_adder_fa.sv
// serial_adder_fa: half_adder cell and the full_adder built from two of them
// half_adder: a, b in; sum, carry out
// full_adder: a, b, cin in; sum, cout out
module half_adder (
    input  logic a,
    input  logic b,
    output logic sum,
    output logic carry
);
    assign sum   = a ^ b;
    assign carry = a & b;
endmodule

module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    logic s0, c0, c1;
    half_adder u_ha0 (.a(a),  .b(b),   .sum(s0),  .carry(c0));
    half_adder u_ha1 (.a(s0), .b(cin), .sum(sum), .carry(c1));
    assign cout = c0 | c1;
endmodule

// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder, one operand bit pair per clock, LSB first
// clk, rst (sync, active-high); sa_if slave: start/a/b/cin in, busy/done/sum/cout out
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic            clk,
    input  logic            rst,
    serial_adder_if.slave   sa_if
);
    localparam int CW = $clog2(WIDTH + 1);

    state_e           state_q;
    logic [WIDTH-1:0] a_q, b_q, acc_q, sum_q;
    logic [CW-1:0]    cnt_q;
    logic             carry_q, cout_q, busy_q, done_q;
    logic             s_bit, c_bit, accept;
    logic [WIDTH-1:0] acc_d;

    full_adder u_fa (.a(a_q[0]), .b(b_q[0]), .cin(carry_q), .sum(s_bit), .cout(c_bit));

    // new sum bit enters at the MSB so the LSB-first stream lands in place after WIDTH shifts
    assign acc_d  = WIDTH'({s_bit, acc_q} >> 1);
    assign accept = sa_if.start && (state_q == IDLE || state_q == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state_q == SHIFT) begin
                a_q     <= a_q >> 1;
                b_q     <= b_q >> 1;
                carry_q <= c_bit;
                acc_q   <= acc_d;
                cnt_q   <= cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_q <= DONE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    sum_q   <= acc_d;
                    cout_q  <= c_bit;
                end
            end else if (accept) begin
                a_q     <= sa_if.a;
                b_q     <= sa_if.b;
                carry_q <= sa_if.cin;
                cnt_q   <= '0;
                state_q <= SHIFT;
                busy_q  <= 1'b1;
            end else begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
            end
        end
    end

    assign sa_if.busy = busy_q;
    assign sa_if.done = done_q;
    assign sa_if.sum  = sum_q;
    assign sa_if.cout = cout_q;
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: scoreboard bench for serial_adder at WIDTH 1, 8 and 16
module tb_serial_adder;
    typedef struct {
        logic [32:0] res;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    exp_t q1[$], q8[$], q16[$];

    serial_adder_if #(.WIDTH(1))  if1 ();
    serial_adder_if #(.WIDTH(8))  if8 ();
    serial_adder_if #(.WIDTH(16)) if16 ();

    serial_adder #(.WIDTH(1))  dut1  (.clk(clk), .rst(rst), .sa_if(if1));
    serial_adder #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .sa_if(if8));
    serial_adder #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .sa_if(if16));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [32:0] res_of(input int w);
        case (w)
            1:       res_of = 33'({if1.cout, if1.sum});
            8:       res_of = 33'({if8.cout, if8.sum});
            default: res_of = 33'({if16.cout, if16.sum});
        endcase
    endfunction

    function automatic logic [32:0] hs(input int w);
        case (w)
            1:       hs = 33'({if1.done, if1.busy});
            8:       hs = 33'({if8.done, if8.busy});
            default: hs = 33'({if16.done, if16.busy});
        endcase
    endfunction

    function automatic logic [32:0] model(input int w, input logic [31:0] a, input logic [31:0] b, input logic c);
        logic [32:0] m;
        m = (33'd1 << w) - 33'd1;
        model = ((33'(a) & m) + (33'(b) & m) + 33'(c)) & ((33'd1 << (w + 1)) - 33'd1);
    endfunction

    // monitor: pops the scoreboard whenever any DUT presents done
    task automatic mon(input int w);
        exp_t e;
        bit   ok;
        ok = 0;
        case (w)
            1:       if (q1.size() > 0)  begin e = q1.pop_front();  ok = 1; end
            8:       if (q8.size() > 0)  begin e = q8.pop_front();  ok = 1; end
            default: if (q16.size() > 0) begin e = q16.pop_front(); ok = 1; end
        endcase
        if (!ok) begin
            n_tests++;
            n_fail++;
            $display("FAIL done_unexpected w=%0d cyc=%0d got=done expected=no_done", w, cyc);
        end else begin
            check($sformatf("result_w%0d", w), res_of(w), e.res);
            check($sformatf("latency_w%0d", w), 33'(cyc), 33'(e.due));
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (if1.done)  mon(1);
            if (if8.done)  mon(8);
            if (if16.done) mon(16);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if1.start  = 1'b0;
        if8.start  = 1'b0;
        if16.start = 1'b0;
    endtask

    task automatic drive(input int w, input logic [31:0] a, input logic [31:0] b, input logic c,
                         input bit push, input logic [32:0] e);
        exp_t x;
        x.res = e;
        x.due = cyc + w + 1;
        case (w)
            1:       begin if1.start = 1'b1;  if1.a = a[0];     if1.b = b[0];     if1.cin = c;  end
            8:       begin if8.start = 1'b1;  if8.a = a[7:0];   if8.b = b[7:0];   if8.cin = c;  end
            default: begin if16.start = 1'b1; if16.a = a[15:0]; if16.b = b[15:0]; if16.cin = c; end
        endcase
        if (push) begin
            case (w)
                1:       q1.push_back(x);
                8:       q8.push_back(x);
                default: q16.push_back(x);
            endcase
        end
    endtask

    // issues an op and walks it to its done cycle, checking busy/done every cycle
    task automatic op(input int w, input logic [31:0] a, input logic [31:0] b, input logic c, input logic [32:0] e);
        drive(w, a, b, c, 1, e);
        for (int k = 1; k <= w; k++) begin
            step();
            check("busy_phase", hs(w), 33'd1);
        end
        step();
        check("done_phase", hs(w), 33'd2);
    endtask

    initial begin
        #1ms;
        $display("FAIL timeout cyc=%0d got=running expected=finished", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] ra, rb;
        logic        rc;
        int          n0;
        if1.start = 0;  if1.a = '0;  if1.b = '0;  if1.cin = 0;
        if8.start = 0;  if8.a = '0;  if8.b = '0;  if8.cin = 0;
        if16.start = 0; if16.a = '0; if16.b = '0; if16.cin = 0;
        #1;
        // reset held with start asserted
        rst = 1'b1;
        repeat (2) begin
            if8.start = 1'b1;
            if8.a = 8'hFF;
            if8.b = 8'h01;
            @(posedge clk);
            #1;
            check("rst_handshake", hs(8), 33'd0);
            check("rst_result", res_of(8), 33'h000);
        end
        if8.start = 1'b0;
        rst = 1'b0;
        step();
        check("no_start_in_rst", hs(8), 33'd0);
        // basic
        step();
        op(8, 32'h0F, 32'h01, 1'b0, 33'h010);
        // carry ripple
        step();
        op(8, 32'hFF, 32'h01, 1'b0, 33'h100);
        step();
        op(8, 32'hFF, 32'hFF, 1'b1, 33'h1FF);
        // handshake: ignored start mid-op, back-to-back start in done cycle
        step();
        n0 = cyc;
        drive(8, 32'h12, 32'h34, 1'b0, 1, 33'h046);
        repeat (4) step();
        drive(8, 32'hAA, 32'h34, 1'b0, 0, 33'h0);
        repeat (5) step();
        check("hs_done_cycle", 33'(cyc - n0), 33'd9);
        check("hs_done", hs(8), 33'd2);
        check("hs_sum", res_of(8), 33'h046);
        drive(8, 32'h01, 32'h02, 1'b0, 1, 33'h003);
        for (int k = 10; k <= 17; k++) begin
            step();
            check("hs2_busy", hs(8), 33'd1);
            check("hs_hold", res_of(8), 33'h046);
        end
        step();
        check("hs2_done", hs(8), 33'd2);
        // abort by reset in cycle 4
        step();
        drive(8, 32'h05, 32'h03, 1'b0, 0, 33'h0);
        repeat (4) step();
        check("abort_busy_before", hs(8), 33'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort_hs", hs(8), 33'd0);
        check("abort_result", res_of(8), 33'h000);
        repeat (12) step();
        op(8, 32'h05, 32'h03, 1'b0, 33'h008);
        // random, back-to-back from each done cycle
        for (int i = 0; i < 1000; i++) begin
            ra = $urandom; rb = $urandom; rc = 1'($urandom);
            op(8, ra, rb, rc, model(8, ra, rb, rc));
        end
        for (int i = 0; i < 200; i++) begin
            ra = $urandom; rb = $urandom; rc = 1'($urandom);
            op(1, ra, rb, rc, model(1, ra, rb, rc));
        end
        for (int i = 0; i < 200; i++) begin
            ra = $urandom; rb = $urandom; rc = 1'($urandom);
            op(16, ra, rb, rc, model(16, ra, rb, rc));
        end
        repeat (3) step();
        check("scoreboard_drained", 33'(q1.size() + q8.size() + q16.size()), 33'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
